// File: rtl/video_pkg.sv
// video_pkg: framebuffer geometry, DAC codes and pixel-RAM arbiter state shared by the video blocks.
package video_pkg;
  localparam int H_PIXELS = 320;
  localparam int V_PIXELS = 240;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 2;
  localparam int MEM_WORDS = H_PIXELS * V_PIXELS;
  localparam int FIFO_DEPTH = 4;
  localparam logic [1:0] SYNC = 2'b00;
  localparam logic [1:0] BLACK = 2'b01;
  typedef enum logic [1:0] {IDLE, WAIT, FILL} arb_state_e;
endpackage

// File: rtl/pixelmem_wfifo.sv
// pixelmem_wfifo: small synchronous FIFO buffering host pixel writes until the RAM port is free.
module pixelmem_wfifo #(
  parameter int W = 19,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic push, pull;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = wr_q == rd_q;
  assign full = wr_q == {~rd_q[PW], rd_q[PW-1:0]};
  assign push_ready = !full;
  assign push = push_valid && !full;
  assign pull = pop && !empty;
  assign head = mem_q[rd_q[PW-1:0]];
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pull ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PW-1:0]] <= push_data;
  end
endmodule

// File: rtl/pixelmem_arbiter.sv
// pixelmem_arbiter: shares the pixel RAM between scan-out reads, buffered host writes and a fill engine.
module pixelmem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 2,
  parameter int MEM_WORDS = 76800,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_data_valid,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              fill_req,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              oob_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  import video_pkg::*;
  localparam int FW = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_WORDS - 1);
  arb_state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic vid_valid_q, vid_valid_d, busy_q, busy_d, done_q, done_d, oob_q, oob_d;
  logic [FW-1:0] head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic full, empty, fifo_ready, push, pop, head_ok, fill_we, last;
  pixelmem_wfifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_wfifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push),
    .push_ready (fifo_ready),
    .push_data  ({host_addr, host_data}),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );
  assign {head_addr, head_data} = head;
  assign host_ready = fifo_ready && state_q == IDLE;
  assign push = host_valid && host_ready;
  // Scan-out owns the port whenever it asks; FIFO drains before the fill advances.
  assign pop = !vid_req && !empty;
  assign head_ok = head_addr <= LAST;
  assign fill_we = !vid_req && empty && state_q == FILL;
  assign last = cnt_q == LAST;
  assign ram_addr = vid_req ? vid_addr : pop ? head_addr : fill_we ? cnt_q : '0;
  assign ram_we = pop ? head_ok : fill_we;
  assign ram_wdata = vid_req ? '0 : pop ? head_data : fill_we ? color_q : '0;
  assign vid_data = ram_rdata;
  assign vid_data_valid = vid_valid_q;
  assign fill_busy = busy_q;
  assign fill_done = done_q;
  assign oob_err = oob_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    color_d = color_q;
    busy_d = busy_q;
    done_d = 1'b0;
    vid_valid_d = vid_req;
    oob_d = oob_q || (pop && !head_ok);
    if (state_q == IDLE && fill_req) begin
      state_d = WAIT;
      color_d = fill_color;
      busy_d = 1'b1;
    end else if (state_q == WAIT && empty) begin
      state_d = FILL;
      cnt_d = '0;
    end else if (fill_we) begin
      cnt_d = last ? cnt_q : cnt_q + 1'b1;
      state_d = last ? IDLE : FILL;
      busy_d = !last;
      done_d = last;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      color_q <= '0;
      vid_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      oob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      color_q <= color_d;
      vid_valid_q <= vid_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      oob_q <= oob_d;
    end
  end
endmodule

// File: tb/tb_pixelmem_arbiter.sv
// tb_pixelmem_arbiter: directed checks of read pass-through, host write buffering, fill and reset abort.
module tb_pixelmem_arbiter;
  localparam int AW = 17;
  localparam int DW = 2;
  localparam int MEM = 1200;
  logic clk = 1'b0;
  logic reset;
  logic vid_req, vid_data_valid, host_valid, host_ready, fill_req, fill_busy, fill_done, oob_err, ram_we;
  logic [AW-1:0] vid_addr, host_addr, ram_addr;
  logic [DW-1:0] vid_data, host_data, fill_color, ram_wdata, ram_rdata;
  logic [1:0] mem [MEM];
  logic [AW+DW-1:0] wq [$];
  int we_cnt, done_cnt, viol, checks, errors;

  pixelmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MEM), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .vid_req        (vid_req),
    .vid_addr       (vid_addr),
    .vid_data       (vid_data),
    .vid_data_valid (vid_data_valid),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_addr      (host_addr),
    .host_data      (host_data),
    .fill_req       (fill_req),
    .fill_color     (fill_color),
    .fill_busy      (fill_busy),
    .fill_done      (fill_done),
    .oob_err        (oob_err),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we && int'(ram_addr) < MEM) mem[ram_addr] <= ram_wdata;
    ram_rdata <= int'(ram_addr) < MEM ? mem[ram_addr] : 2'b00;
  end

  always @(posedge clk) begin
    if (reset) begin
      if (ram_we) begin
        we_cnt <= we_cnt + 1;
        wq.push_back({ram_addr, ram_wdata});
      end
      if (fill_done) done_cnt <= done_cnt + 1;
      if ((ram_we && vid_req) || (fill_busy && host_ready) || (fill_done && fill_busy)) viol <= viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    we_cnt = 0;
    done_cnt = 0;
    wq.delete();
  endtask

  function automatic logic [AW+DW-1:0] ent(input int a, input int d);
    return {a[AW-1:0], d[DW-1:0]};
  endfunction

  function automatic int mem_bad(input logic [1:0] c);
    int n = 0;
    for (int i = 0; i < MEM; i++) if (mem[i] !== c) n++;
    return n;
  endfunction

  task automatic fill_wait(input string tag, input bit toggle);
    int n = 0;
    while (!fill_done && n < 3000) begin
      vid_req = toggle && n[0];
      fill_req = n == 50;
      fill_color = 2'b10;
      tick();
      n++;
    end
    vid_req = 1'b0;
    fill_req = 1'b0;
    chk({tag, "_done_seen"}, fill_done, 1);
    chk({tag, "_busy_at_done"}, fill_busy, 0);
    tick();
    chk({tag, "_done_pulse"}, fill_done, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    viol = 0;
    clr();
    for (int i = 0; i < MEM; i++) mem[i] = 2'b00;
    reset = 1'b0;
    {vid_req, host_valid, fill_req} = '0;
    vid_addr = '0;
    host_addr = '0;
    host_data = '0;
    fill_color = '0;
    #3;
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_valid", vid_data_valid, 0);
    chk("rst_oob", oob_err, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_ready", host_ready, 1);
    tick();
    tick();
    reset = 1'b1;
    mem[5] = 2'b10;
    vid_req = 1'b1;
    vid_addr = 17'd5;
    #1;
    chk("rd_addr", ram_addr, 5);
    chk("rd_we", ram_we, 0);
    tick();
    chk("rd_data", vid_data, 2'b10);
    chk("rd_valid", vid_data_valid, 1);
    vid_req = 1'b0;
    tick();
    chk("rd_valid_drop", vid_data_valid, 0);

    clr();
    host_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_addr = AW'(i);
      host_data = 2'd3;
      #1;
      chk("hw_ready", host_ready, 1);
      tick();
    end
    host_valid = 1'b0;
    tick();
    tick();
    chk("hw_count", we_cnt, 4);
    for (int i = 0; i < 4; i++) chk("hw_order", wq[i], ent(i, 3));

    clr();
    vid_req = 1'b1;
    vid_addr = 17'd7;
    host_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_addr = AW'(20 + i);
      host_data = DW'(i);
      #1;
      chk("bp_ready", host_ready, i < 4);
      tick();
    end
    host_valid = 1'b0;
    tick();
    tick();
    chk("bp_starved", we_cnt, 0);
    vid_req = 1'b0;
    repeat (5) tick();
    chk("bp_drain", we_cnt, 4);
    for (int i = 0; i < 4; i++) chk("bp_order", wq[i], ent(20 + i, i));
    chk("bp_ready_back", host_ready, 1);

    clr();
    host_valid = 1'b1;
    host_addr = AW'(MEM);
    host_data = 2'd3;
    tick();
    chk("oob_not_yet", oob_err, 0);
    host_addr = AW'(76800);
    tick();
    chk("oob_set", oob_err, 1);
    host_addr = 17'd10;
    host_data = 2'd2;
    tick();
    host_valid = 1'b0;
    repeat (3) tick();
    chk("oob_we_cnt", we_cnt, 1);
    chk("oob_good_write", wq[0], ent(10, 2));
    chk("oob_mem10", mem[10], 2);
    chk("oob_sticky", oob_err, 1);

    clr();
    viol = 0;
    vid_req = 1'b1;
    host_valid = 1'b1;
    host_addr = 17'd100;
    host_data = 2'd3;
    tick();
    host_addr = 17'd101;
    host_data = 2'd2;
    tick();
    host_valid = 1'b0;
    fill_req = 1'b1;
    fill_color = 2'd1;
    tick();
    fill_req = 1'b0;
    chk("fill_busy", fill_busy, 1);
    chk("fill_ready_low", host_ready, 0);
    fill_wait("fill1", 1'b1);
    chk("fill1_done_once", done_cnt, 1);
    chk("fill1_we_cnt", we_cnt, MEM + 2);
    chk("fill1_fifo0", wq[0], ent(100, 3));
    chk("fill1_fifo1", wq[1], ent(101, 2));
    begin
      int bad = 0;
      for (int i = 0; i < MEM; i++) if (wq[i + 2] !== ent(i, 1)) bad++;
      chk("fill1_sweep_order", bad, 0);
    end
    chk("fill1_mem", mem_bad(2'd1), 0);
    chk("fill1_viol", viol, 0);
    chk("fill1_ready_back", host_ready, 1);

    fill_req = 1'b1;
    fill_color = 2'd2;
    tick();
    fill_req = 1'b0;
    begin
      int n = 0;
      while (!(ram_we && ram_addr == 17'd1000) && n < 2000) begin
        tick();
        n++;
      end
      chk("abort_reached_1000", ram_addr, 1000);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", fill_busy, 0);
    chk("abort_we", ram_we, 0);
    chk("abort_oob_clr", oob_err, 0);
    tick();
    tick();
    reset = 1'b1;
    clr();
    repeat (20) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_ready", host_ready, 1);
    chk("abort_no_we", we_cnt, 0);
    fill_req = 1'b1;
    fill_color = 2'd3;
    tick();
    fill_req = 1'b0;
    fill_wait("fill2", 1'b0);
    chk("fill2_done_once", done_cnt, 1);
    chk("fill2_we_cnt", we_cnt, MEM);
    chk("fill2_mem", mem_bad(2'd3), 0);
    chk("fill2_viol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixelmem_arbiter.md
Name: pixelmem_arbiter

Overview:
- Shares the single-port 2-bit pixel RAM (320x240 = 76800 words) between the NTSC scan-out reader and a host writer.
- Adds a hardware framebuffer fill engine.
- Scan-out reads always win. Host writes are buffered in a small FIFO and drained on cycles the scan-out leaves free. The fill engine sweeps the whole RAM with one colour.
- Sits between the video generator's pixelmem_address/pixelmem_data port and the RAM.

Parameters:
ADDR_W, 17, pixel address width
DATA_W, 2, pixel width (DAC code)
MEM_WORDS, 76800, framebuffer size; legal addresses 0..MEM_WORDS-1
FIFO_DEPTH, 4, host write FIFO entries (power of two)

Ports:
clk  in  1  system clock (video pixel clock)
reset  in  1  asynchronous, active-low reset (asserted when 0)
vid_req  in  1  scan-out read request this cycle
vid_addr  in  ADDR_W  scan-out read address
vid_data  out  DATA_W  read data, valid one cycle after grant
vid_data_valid  out  1  high the cycle vid_data carries granted read data
host_valid  in  1  host write offered
host_ready  out  1  FIFO can accept; transfer when host_valid && host_ready
host_addr  in  ADDR_W  host write address
host_data  in  DATA_W  host write pixel
fill_req  in  1  single-cycle pulse: request framebuffer fill
fill_color  in  DATA_W  fill colour, sampled with fill_req
fill_busy  out  1  fill pending or in progress
fill_done  out  1  one-cycle pulse after the last fill write
oob_err  out  1  sticky: host write to address >= MEM_WORDS was dropped
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM synchronous read data, 1-cycle latency

Behaviour:
- Reset (reset=0, async): FIFO flushed; state IDLE; fill pending cleared; fill counter 0; vid_data_valid=0; fill_busy=0; fill_done=0; oob_err=0.
- Reset values of the combinational RAM outputs: ram_we=0, ram_wdata=0, and ram_addr=0 when vid_req=0.
- host_ready=1 out of reset.
- Reset mid-fill aborts the fill; no fill_done is produced.
- RAM port select is combinational, so there is zero grant latency. Per-cycle priority:
  1. vid_req=1: ram_addr=vid_addr, ram_we=0.
  2. Else, FIFO non-empty: pop the head; ram_addr=head addr, ram_wdata=head data, ram_we=1 (ram_we=0 if addr >= MEM_WORDS, and set oob_err).
  3. Else, state FILL: ram_addr=fill counter, ram_wdata=latched colour, ram_we=1; counter advances.
  4. Else: ram_we=0, ram_addr=0, ram_wdata=0.
- vid_data=ram_rdata, passed straight through.
- vid_data_valid is registered: equals the previous cycle's vid_req.
- FIFO: push on host_valid&&host_ready; pop on grant per priority 2.
  - Push and pop in the same cycle: occupancy unchanged.
  - Push is accepted only if not full; no overflow is possible.
  - Write order is preserved.
- host_ready = !full && !fill_pending && state==IDLE.
- State machine, states IDLE, WAIT, FILL:
  - IDLE: fill_req=1 -> latch fill_color, fill_busy=1, go to WAIT.
  - WAIT: host_ready=0; the FIFO keeps draining. When the FIFO is empty, counter=0 and go to FILL.
  - FILL: one write per cycle not taken by vid_req. After writing address MEM_WORDS-1, go to IDLE next cycle, pulse fill_done for 1 cycle, and drop fill_busy in that same cycle.
  - fill_req while fill_busy=1 is ignored.
- Ordering guarantee: host writes accepted before fill_req are overwritten by the fill. Writes accepted after fill_done persist.
- Counter width is ADDR_W. The counter never exceeds MEM_WORDS-1; there is no wrap.
- Continuous vid_req starves FIFO and fill indefinitely. This is legal: blanking periods guarantee progress.

Decomposition:
- Shared package video_pkg:
  - ADDR_W, DATA_W, MEM_WORDS, the 320/240 dimensions.
  - DAC code constants: SYNC=2'b00, BLACK=2'b01.
  - Arbiter state enum {IDLE, WAIT, FILL}.
- Sub-module pixelmem_wfifo: synchronous FIFO with valid/ready push, pop strobe, head outputs, full/empty.
- Arbitration and the fill FSM stay in pixelmem_arbiter.

Test Plan:
- Read pass-through: vid_req=1, addr=5, RAM preloaded 2'b10 -> ram_addr=5, ram_we=0; next cycle vid_data=2'b10, vid_data_valid=1.
- Host writes during idle video: 4 writes (addr 0..3, data 3) back-to-back -> 4 consecutive ram_we=1 cycles in order; host_ready stays 1.
- Starvation and backpressure: vid_req held 1, 5 host writes offered -> 4 accepted, host_ready=0 on the 5th, no ram_we. Drop vid_req -> 4 writes drain in order, host_ready returns 1.
- Fill with interleaved reads:
  - Sequence: 2 FIFO entries pending; fill_req with colour 1; vid_req toggling every other cycle.
  - Required response: the FIFO drains first, then all 76800 addresses are written with 1.
  - Required response: fill_done pulses exactly once, and host_ready=0 throughout.
  - Required response: RAM contents all 1.
- Out of range: host write addr=76800 -> no ram_we for it, oob_err=1 and stays set; a subsequent write to addr 10 succeeds.
- Async reset mid-fill: reset=0 at fill address 1000, asynchronously between clock edges -> fill_busy=0 and ram_we=0 immediately, no fill_done. After release, host_ready=1 and a new fill completes normally.
